// File: rtl/cpu_pkg.sv
// Shared types and decode constants for the LEGv8 fetch stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } fetch_state_t;

  localparam logic [7:0] OPC_CBZ   = 8'hB4;
  localparam logic [7:0] OPC_BCOND = 8'h54;
  localparam logic [4:0] COND_LT   = 5'b01011;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, B, CBZ and B.LT targets.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              UBranch,
  input  logic              Branch,
  input  logic              alu_zero,
  input  logic              flag_n,
  input  logic              flag_v,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] off_b;
  logic [ADDR_W-1:0] off_cond;
  logic [ADDR_W-1:0] seq_pc;
  logic              is_cbz;
  logic              is_blt;

  // Offsets are word counts: sign-extend, then scale by 4 via the appended zeros.
  always_comb begin
    off_b    = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
    off_cond = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
    seq_pc   = pc + ADDR_W'(4);
    is_cbz   = (instr[31:24] == OPC_CBZ);
    is_blt   = (instr[31:24] == OPC_BCOND) && (instr[4:0] == COND_LT);
    next_pc  = seq_pc;
    if (UBranch) begin
      next_pc = pc + off_b;
    end else if (Branch) begin
      if (is_cbz && alu_zero) begin
        next_pc = pc + off_cond;
      end else if (is_blt && (flag_n ^ flag_v)) begin
        next_pc = pc + off_cond;
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// LEGv8 fetch stage: PC, instruction-memory handshake, instruction latch and retire counter.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic [10:0]       opcode,
  output logic              instr_valid,
  input  logic              advance,
  input  logic              UBranch,
  input  logic              Branch,
  input  logic              alu_zero,
  input  logic              flag_n,
  input  logic              flag_v,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  retired
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [ADDR_W-1:0] next_pc;
  logic              in_decode;

  assign in_decode = (state_q == DECODE);

  // Branch controls only matter on the advance cycle; mask them otherwise.
  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc       (pc_q),
    .instr    (instr_q),
    .UBranch  (UBranch & in_decode),
    .Branch   (Branch & in_decode),
    .alu_zero (alu_zero),
    .flag_n   (flag_n),
    .flag_v   (flag_v),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      RESET: state_d = FETCH;
      FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (advance) begin
          pc_d      = next_pc;
          retired_d = retired_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:21];
  assign instr_valid = in_decode;
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: driver pushes expectations, negedge monitor checks them.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instr_valid;
  logic        advance;
  logic        ubranch, branch, alu_zero, flag_n, flag_v;
  logic [63:0] pc;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ret;
  } fetch_exp_t;

  fetch_exp_t  exp_fetch_q[$];
  logic [31:0] exp_instr_q[$];
  logic [63:0] m_pc;
  logic [31:0] m_ret;

  ifetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .advance(advance), .UBranch(ubranch), .Branch(branch),
    .alu_zero(alu_zero), .flag_n(flag_n), .flag_v(flag_v),
    .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: branch rules evaluated with plain signed integer arithmetic.
  function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] w,
                                             input bit ub_i, input bit br_i, input bit z_i,
                                             input bit n_i, input bit v_i);
    longint o26, o19;
    o26 = longint'(w[25:0]);
    if (w[25]) o26 = o26 - 67108864;
    o19 = longint'(w[23:5]);
    if (w[23]) o19 = o19 - 524288;
    if (ub_i) return p + 64'(o26 * 4);
    if (br_i && w[31:24] == 8'hB4) return z_i ? p + 64'(o19 * 4) : p + 64'd4;
    if (br_i && w[31:24] == 8'h54 && w[4:0] == 5'd11 && n_i != v_i) return p + 64'(o19 * 4);
    return p + 64'd4;
  endfunction

  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [18:0] imm);
    return {8'hB4, imm, 5'd0};
  endfunction
  function automatic logic [31:0] enc_bcond(input logic [18:0] imm, input logic [4:0] cond);
    return {8'h54, imm, cond};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_req: imem_req=%b after 20 cycles, expected 1", imem_req);
    end
  endtask

  task automatic run_instr(input logic [31:0] word, input int stall, input int adv_dly,
                           input bit ub_i, input bit br_i, input bit z_i,
                           input bit n_i, input bit v_i);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < stall; i++) begin
      imem_valid = 1'b0;
      advance    = 1'($urandom_range(0, 1));
      step();
    end
    advance    = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = word;
    exp_instr_q.push_back(word);
    step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i < adv_dly; i++) begin
      {ubranch, branch, alu_zero, flag_n, flag_v} = 5'($urandom);
      step();
    end
    ubranch  = ub_i;
    branch   = br_i;
    alu_zero = z_i;
    flag_n   = n_i;
    flag_v   = v_i;
    advance  = 1'b1;
    m_pc  = model_next(m_pc, word, ub_i, br_i, z_i, n_i, v_i);
    m_ret = m_ret + 32'd1;
    exp_fetch_q.push_back('{pc: m_pc, ret: m_ret});
    step();
    advance = 1'b0;
    {ubranch, branch} = 2'b00;
  endtask

  task automatic goto_pc(input logic [63:0] target);
    longint d;
    logic [25:0] imm;
    d   = longint'(target - m_pc) / 4;
    imm = d[25:0];
    run_instr(enc_b(imm), 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, 64'd0);
    chk({tag, "_instr"}, {32'd0, instr}, 64'd0);
    chk({tag, "_opcode"}, {53'd0, opcode}, 64'd0);
    chk({tag, "_instr_valid"}, {63'd0, instr_valid}, 64'd0);
    chk({tag, "_imem_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_retired"}, {32'd0, retired}, 64'd0);
  endtask

  // Monitor: fetch starts and decode starts each consume one expectation.
  logic        prev_req = 1'b0, prev_iv = 1'b0;
  logic [63:0] cur_pc;
  logic [31:0] cur_instr;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_req = 1'b0;
      prev_iv  = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        if (exp_fetch_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fetch_unexpected: imem_addr=%h with no pending expectation", imem_addr);
          cur_pc = imem_addr;
        end else begin
          fetch_exp_t e;
          e = exp_fetch_q.pop_front();
          cur_pc = e.pc;
          chk("fetch_addr", imem_addr, e.pc);
          chk("fetch_pc", pc, e.pc);
          chk("fetch_retired", {32'd0, retired}, {32'd0, e.ret});
        end
      end else if (imem_req) begin
        chk("stall_addr", imem_addr, cur_pc);
      end
      if (imem_req) chk("stall_no_valid", {63'd0, instr_valid}, 64'd0);
      if (instr_valid && !prev_iv) begin
        if (exp_instr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL decode_unexpected: instr=%h with no pending expectation", instr);
          cur_instr = instr;
        end else begin
          cur_instr = exp_instr_q.pop_front();
          chk("decode_instr", {32'd0, instr}, {32'd0, cur_instr});
          chk("decode_opcode", {53'd0, opcode}, {53'd0, cur_instr[31:21]});
        end
      end else if (instr_valid) begin
        chk("decode_hold", {32'd0, instr}, {32'd0, cur_instr});
      end
      prev_req = imem_req;
      prev_iv  = instr_valid;
    end
  end

  initial begin
    bit ok;
    reset_n    = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    advance    = 1'b0;
    {ubranch, branch, alu_zero, flag_n, flag_v} = '0;
    m_pc  = 64'd0;
    m_ret = 32'd0;
    #1;
    check_reset_outputs("por");
    repeat (2) step();
    reset_n = 1'b1;
    exp_fetch_q.push_back('{pc: 64'd0, ret: 32'd0});

    // Directed plan.
    run_instr(32'h91000421, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h8B020020, 0, 1, 0, 0, 0, 0, 0);
    run_instr(32'h91000842, 3, 0, 0, 0, 0, 0, 0);
    goto_pc(64'h40);
    run_instr(enc_b(-26'sd2), 0, 0, 1, 0, 0, 0, 0);
    goto_pc(64'h40);
    run_instr(enc_b(-26'sd2), 1, 0, 1, 1, 1, 1, 0);
    goto_pc(64'h100);
    run_instr(enc_cbz(19'd4), 0, 0, 0, 1, 1, 0, 0);
    goto_pc(64'h100);
    run_instr(enc_cbz(19'd4), 0, 0, 0, 1, 0, 0, 0);
    goto_pc(64'h20);
    run_instr(enc_bcond(19'd2, 5'b01011), 0, 0, 0, 1, 0, 1, 0);
    goto_pc(64'h20);
    run_instr(enc_bcond(19'd2, 5'b01011), 0, 0, 0, 1, 0, 1, 1);
    goto_pc(64'h20);
    run_instr(enc_bcond(19'd2, 5'b00000), 0, 0, 0, 1, 0, 1, 0);
    goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(32'h91000421, 2, 0, 0, 0, 0, 0, 0);

    // Randomized mix of instruction shapes and handshake timing.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] w;
      logic [4:0]  cnd;
      cnd = ($urandom_range(0, 1) == 1) ? 5'b01011 : 5'($urandom);
      case ($urandom_range(0, 3))
        0: w = $urandom;
        1: w = enc_cbz(19'($urandom));
        2: w = enc_bcond(19'($urandom), cnd);
        default: w = enc_b(26'($urandom));
      endcase
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset while holding an instruction in DECODE, then a stale strobe during RESET.
    wait_req(ok);
    imem_valid = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    exp_instr_q.push_back(32'hCAFE_0001);
    step();
    imem_valid = 1'b0;
    chk("pre_reset_decode", {63'd0, instr_valid}, 64'd1);
    #5;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_fetch_q.delete();
    exp_instr_q.delete();
    m_pc  = 64'd0;
    m_ret = 32'd0;
    step();
    reset_n    = 1'b1;
    exp_fetch_q.push_back('{pc: 64'd0, ret: 32'd0});
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0;
    run_instr(32'h91000421, 1, 0, 0, 0, 0, 0, 0);
    run_instr(enc_cbz(-19'sd1), 0, 0, 0, 1, 1, 0, 0);

    repeat (3) step();
    chk("queues_drained", 64'(exp_fetch_q.size() + exp_instr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
